// File: rtl/div16x8_seq.sv
// Sequential signed divider: restoring division on operand magnitudes,
// one quotient bit per clock, with sign fix-up and divide-by-zero/overflow flags.
module div16x8_seq #(
    parameter int DIVIDEND_LEN = 16,
    parameter int DIVISOR_LEN  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIVIDEND_LEN-1:0] dividend,
    input  logic [DIVISOR_LEN-1:0]  divisor,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIVIDEND_LEN-1:0] quotient,
    output logic [DIVISOR_LEN-1:0]  remainder,
    output logic                    div_by_zero,
    output logic                    overflow
);

    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // CALC  | one restoring-division step per cycle, MSB first
    // FIX   | apply signs to quotient/remainder magnitudes
    // DONE  | result presented, out_valid high until accepted
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int CNT_W = $clog2(DIVIDEND_LEN);

    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [DIVIDEND_LEN-1:0] r_dvd_mag;
    logic [DIVISOR_LEN-1:0]  r_dvs_mag;
    logic [DIVISOR_LEN:0]    r_prem;
    logic                    r_sign_q;
    logic                    r_sign_r;
    logic                    r_ovf_next;
    logic [DIVIDEND_LEN-1:0] r_quotient;
    logic [DIVISOR_LEN-1:0]  r_remainder;
    logic                    r_dbz;
    logic                    r_ovf;

    logic [DIVIDEND_LEN-1:0] w_dvd_abs;
    logic [DIVISOR_LEN-1:0]  w_dvs_abs;
    logic                    w_ovf_case;
    logic [DIVISOR_LEN+1:0]  w_shift;
    logic                    w_ge;
    logic [DIVISOR_LEN:0]    w_diff;
    logic                    w_accept;

    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_dvd_abs  = dividend[DIVIDEND_LEN-1] ? -dividend : dividend;
    assign w_dvs_abs  = divisor[DIVISOR_LEN-1]   ? -divisor  : divisor;
    assign w_ovf_case = (dividend == {1'b1, {(DIVIDEND_LEN-1){1'b0}}}) &&
                        (divisor == {DIVISOR_LEN{1'b1}});

    // Partial remainder never exceeds the divisor magnitude, so the top of
    // w_shift only matters for the compare; the difference fits in DIVISOR_LEN+1 bits.
    assign w_shift = {r_prem, r_dvd_mag[DIVIDEND_LEN-1]};
    assign w_ge    = w_shift >= {2'b00, r_dvs_mag};
    assign w_diff  = w_shift[DIVISOR_LEN:0] - {1'b0, r_dvs_mag};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_dvd_mag   <= '0;
            r_dvs_mag   <= '0;
            r_prem      <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_ovf_next  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign_q   <= dividend[DIVIDEND_LEN-1] ^ divisor[DIVISOR_LEN-1];
                        r_sign_r   <= dividend[DIVIDEND_LEN-1];
                        r_dvd_mag  <= w_dvd_abs;
                        r_dvs_mag  <= w_dvs_abs;
                        r_ovf_next <= w_ovf_case;
                        r_prem     <= '0;
                        r_cnt      <= '0;
                        if (divisor == '0) begin
                            r_quotient  <= '0;
                            r_remainder <= '0;
                            r_dbz       <= 1'b1;
                            r_ovf       <= 1'b0;
                            r_state     <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // Dividend magnitude shifts out MSB first; quotient bits fill in from the LSB.
                    r_prem    <= w_ge ? w_diff : w_shift[DIVISOR_LEN:0];
                    r_dvd_mag <= {r_dvd_mag[DIVIDEND_LEN-2:0], w_ge};
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(DIVIDEND_LEN-1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_quotient  <= r_sign_q ? -r_dvd_mag : r_dvd_mag;
                    r_remainder <= r_sign_r ? -r_prem[DIVISOR_LEN-1:0] : r_prem[DIVISOR_LEN-1:0];
                    r_ovf       <= r_ovf_next;
                    r_dbz       <= 1'b0;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_div16x8_seq.sv
// Directed bench for div16x8_seq: hand-computed quotients/remainders, latency,
// backpressure hold and mid-calculation reset.
module tb_div16x8_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int n_chk  = 0;
    int n_pass = 0;

    div16x8_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, wait for the result, optionally hold it under backpressure, then release.
    task automatic do_op(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                         input logic [15:0] eq, input logic [7:0] er,
                         input logic edbz, input logic eovf, input int elat, input int hold);
        int lat;
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
        chk({tag, "_remainder"}, 32'(remainder), 32'(er));
        chk({tag, "_flags"}, {30'd0, div_by_zero, overflow}, {30'd0, edbz, eovf});
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold"}, {in_ready, out_valid, quotient, remainder, 6'd0},
                {1'b0, 1'b1, eq, er, 6'd0});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_release"}, {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_state", {in_ready, out_valid, div_by_zero, overflow, quotient, remainder, 4'd0},
            {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 4'd0});

        do_op("p1000_7",   16'd1000,  8'd7,    16'h008E, 8'h06, 1'b0, 1'b0, 18, 5);
        do_op("m1000_7",   16'hFC18,  8'd7,    16'hFF72, 8'hFA, 1'b0, 1'b0, 18, 0);
        do_op("p1000_m7",  16'd1000,  8'hF9,   16'hFF72, 8'h06, 1'b0, 1'b0, 18, 0);
        do_op("min_m128",  16'h8000,  8'h80,   16'h0100, 8'h00, 1'b0, 1'b0, 18, 0);
        do_op("p100_m128", 16'd100,   8'h80,   16'h0000, 8'h64, 1'b0, 1'b0, 18, 0);
        do_op("div0",      16'd1234,  8'h00,   16'h0000, 8'h00, 1'b1, 1'b0, 1,  0);
        do_op("ovf",       16'h8000,  8'hFF,   16'h8000, 8'h00, 1'b0, 1'b1, 18, 0);

        // Reset in the middle of CALC must discard the operation and clear the held result.
        dividend = 16'd1000;
        divisor  = 8'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("calc_busy", {30'd0, in_ready, out_valid}, {30'd0, 1'b0, 1'b0});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_reset", {in_ready, out_valid, div_by_zero, overflow, quotient, remainder, 4'd0},
            {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 4'd0});
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) break;
        end
        chk("no_stale_out", 32'(out_valid), 32'd0);

        do_op("m7_2",      16'hFFF9,  8'd2,    16'hFFFD, 8'hFF, 1'b0, 1'b0, 18, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
